// File: rtl/ctrl_zoom.sv
// Pixel-replication upscaler sequencer: reads each source pixel once and writes it
// as an FxF block (F = 1, 2 or 4) into the frame buffer, as a start/busy/done job.
module ctrl_zoom #(
    parameter int unsigned LARGURA    = 160,
    parameter int unsigned ALTURA     = 120,
    parameter int unsigned SRC_ADDR_W = 15,
    parameter int unsigned ADDR_W     = 19
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic [1:0]            fator,
    output logic                  busy,
    output logic                  done,
    output logic                  erro,
    output logic [SRC_ADDR_W-1:0] rd_addr,
    input  logic [7:0]            rd_data,
    output logic                  wr_en,
    output logic [ADDR_W-1:0]     wr_addr,
    output logic [7:0]            wr_data
);

    localparam int unsigned LIN_W = (ALTURA > 1) ? $clog2(ALTURA) : 1;
    localparam int unsigned COL_W = (LARGURA > 1) ? $clog2(LARGURA) : 1;
    localparam logic [LIN_W-1:0] LIN_LAST = LIN_W'(ALTURA - 1);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(LARGURA - 1);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LER     = 3'd1,
        CAPTURA = 3'd2,
        ESCREVE = 3'd3,
        FIM     = 3'd4
    } state_t;

    state_t             state;
    state_t             state_n;

    logic [1:0]         s;
    logic [1:0]         s_n;
    logic [LIN_W-1:0]   linha;
    logic [LIN_W-1:0]   linha_n;
    logic [COL_W-1:0]   coluna;
    logic [COL_W-1:0]   coluna_n;
    logic [1:0]         di;
    logic [1:0]         di_n;
    logic [1:0]         dj;
    logic [1:0]         dj_n;
    logic [7:0]         pix;
    logic [7:0]         pix_n;

    logic               busy_n;
    logic               done_n;
    logic               erro_n;
    logic               wr_en_n;
    logic [SRC_ADDR_W-1:0] rd_addr_n;
    logic [ADDR_W-1:0]  row_n;
    logic [ADDR_W-1:0]  wr_addr_n;
    logic [7:0]         wr_data_n;

    logic [1:0]         blk_last;
    logic               blk_end;
    logic               pix_last;
    logic               accept;

    // F-1 for the latched scale; s=log2(F) so F = 1<<s
    assign blk_last = 2'((3'd1 << s) - 3'd1);
    assign blk_end  = (di == blk_last) && (dj == blk_last);
    assign pix_last = (linha == LIN_LAST) && (coluna == COL_LAST);
    assign accept   = start && (fator != 2'b11);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= IDLE;
        end else begin
            state <= state_n;
        end
    end

    // Next-state logic
    always_comb begin
        state_n = state;
        case (state)
            IDLE:    if (accept) state_n = LER;
            LER:     state_n = CAPTURA;
            CAPTURA: state_n = ESCREVE;
            ESCREVE: if (blk_end) state_n = pix_last ? FIM : LER;
            FIM:     state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end

    // Next values of the counters and the captured pixel
    always_comb begin
        s_n      = s;
        linha_n  = linha;
        coluna_n = coluna;
        di_n     = di;
        dj_n     = dj;
        pix_n    = pix;
        case (state)
            IDLE: begin
                if (accept) begin
                    // fator encodes log2(F) directly for the legal values
                    s_n      = fator;
                    linha_n  = '0;
                    coluna_n = '0;
                    di_n     = '0;
                    dj_n     = '0;
                end
            end
            CAPTURA: begin
                pix_n = rd_data;
                di_n  = '0;
                dj_n  = '0;
            end
            ESCREVE: begin
                if (dj != blk_last) begin
                    dj_n = dj + 2'd1;
                end else begin
                    dj_n = '0;
                    if (di != blk_last) begin
                        di_n = di + 2'd1;
                    end else begin
                        di_n = '0;
                        if (coluna == COL_LAST) begin
                            coluna_n = '0;
                            linha_n  = linha + LIN_W'(1);
                        end else begin
                            coluna_n = coluna + COL_W'(1);
                        end
                    end
                end
            end
            default: ;
        endcase
    end

    // Output logic: computed from next-cycle state so the registered outputs line up with it
    always_comb begin
        busy_n    = (state_n != IDLE);
        done_n    = (state_n == FIM);
        erro_n    = (state == IDLE) && start && (fator == 2'b11);
        wr_en_n   = (state_n == ESCREVE);
        rd_addr_n = SRC_ADDR_W'(linha_n) * SRC_ADDR_W'(LARGURA) + SRC_ADDR_W'(coluna_n);
        // ((linha<<s)+di)*(LARGURA<<s) rewritten as a constant multiply followed by a shift
        row_n     = (ADDR_W'(linha_n) << s_n) + ADDR_W'(di_n);
        wr_addr_n = ((row_n * ADDR_W'(LARGURA)) << s_n)
                  + (ADDR_W'(coluna_n) << s_n) + ADDR_W'(dj_n);
        wr_data_n = pix_n;
    end

    // Datapath and output registers
    always_ff @(posedge clk) begin
        if (rst) begin
            s       <= '0;
            linha   <= '0;
            coluna  <= '0;
            di      <= '0;
            dj      <= '0;
            pix     <= '0;
            busy    <= 1'b0;
            done    <= 1'b0;
            erro    <= 1'b0;
            wr_en   <= 1'b0;
            rd_addr <= '0;
            wr_addr <= '0;
            wr_data <= '0;
        end else begin
            s       <= s_n;
            linha   <= linha_n;
            coluna  <= coluna_n;
            di      <= di_n;
            dj      <= dj_n;
            pix     <= pix_n;
            busy    <= busy_n;
            done    <= done_n;
            erro    <= erro_n;
            wr_en   <= wr_en_n;
            rd_addr <= rd_addr_n;
            wr_addr <= wr_addr_n;
            wr_data <= wr_data_n;
        end
    end

endmodule

// File: tb/tb_ctrl_zoom.sv
// Scoreboard bench for ctrl_zoom on a 2x2 source image with a 1-cycle read memory.
module tb_ctrl_zoom;

    localparam int W = 2;
    localparam int H = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [1:0]  fator;
    logic        busy;
    logic        done;
    logic        erro;
    logic [14:0] rd_addr;
    logic [7:0]  rd_data;
    logic        wr_en;
    logic [18:0] wr_addr;
    logic [7:0]  wr_data;

    always #5 clk = ~clk;

    ctrl_zoom #(.LARGURA(W), .ALTURA(H)) dut (
        .clk(clk), .rst(rst), .start(start), .fator(fator),
        .busy(busy), .done(done), .erro(erro),
        .rd_addr(rd_addr), .rd_data(rd_data),
        .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data)
    );

    logic [7:0] mem [0:3];

    // Source memory with one cycle of read latency
    always @(posedge clk) rd_data <= (rd_addr < 15'd4) ? mem[rd_addr[1:0]] : 8'hEE;

    typedef struct {
        int addr;
        int data;
    } wr_t;

    wr_t exp_q[$];
    int  checks   = 0;
    int  failures = 0;
    int  fb   [0:63];
    int  wcnt [0:63];
    int  wsnap[0:63];
    int  done_cnt = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Reference model: every source pixel becomes an f x f block in a (W*f)-wide frame
    task automatic push_model(input int f);
        wr_t e;
        for (int y = 0; y < H; y++)
            for (int x = 0; x < W; x++)
                for (int i = 0; i < f; i++)
                    for (int j = 0; j < f; j++) begin
                        e.addr = (y * f + i) * (W * f) + x * f + j;
                        e.data = int'(mem[y * W + x]);
                        exp_q.push_back(e);
                    end
    endtask

    // Monitor: pops the scoreboard on every write and mirrors the frame buffer
    always @(negedge clk) begin
        wr_t e;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write_addr", int'(wr_addr), -1);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", int'(wr_addr), e.addr);
                chk("wr_data", int'(wr_data), e.data);
            end
            if (wr_addr < 19'd64) begin
                fb[wr_addr[5:0]]   = int'(wr_data);
                wcnt[wr_addr[5:0]] = wcnt[wr_addr[5:0]] + 1;
            end
        end
        if (done) done_cnt++;
    end

    task automatic run_job(input logic [1:0] f, input int repulse_at, output int busy_cycles);
        int base;
        int cnt;
        int last_done;
        base = done_cnt;
        if (f != 2'b11) push_model(1 << f);
        start = 1'b1;
        fator = f;
        @(negedge clk);
        start = 1'b0;
        fator = 2'($urandom_range(0, 3));
        if (f == 2'b11) begin
            chk("erro_pulse", int'(erro), 1);
            chk("erro_busy", int'(busy), 0);
            chk("erro_wr_en", int'(wr_en), 0);
            @(negedge clk);
            chk("erro_clear", int'(erro), 0);
            chk("erro_busy_after", int'(busy), 0);
            chk("erro_no_done", done_cnt - base, 0);
            busy_cycles = 0;
        end else begin
            cnt = 0;
            last_done = 0;
            while (busy && cnt < 2000) begin
                cnt++;
                last_done = int'(done);
                if (cnt == repulse_at) begin
                    start = 1'b1;
                    fator = 2'($urandom_range(0, 3));
                end else begin
                    start = 1'b0;
                end
                @(negedge clk);
            end
            start = 1'b0;
            busy_cycles = cnt;
            chk("done_on_last_busy", last_done, 1);
            chk("done_count", done_cnt - base, 1);
            chk("queue_drained", exp_q.size(), 0);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        int bc;
        int n;
        int cnt;
        int base;
        int f;
        for (int a = 0; a < 64; a++) begin
            fb[a]   = 0;
            wcnt[a] = 0;
        end
        rst   = 1'b1;
        start = 1'b0;
        fator = 2'b00;
        mem[0] = 8'd1; mem[1] = 8'd2; mem[2] = 8'd3; mem[3] = 8'd4;
        repeat (2) @(negedge clk);
        chk("rst_busy", int'(busy), 0);
        chk("rst_done", int'(done), 0);
        chk("rst_erro", int'(erro), 0);
        chk("rst_wr_en", int'(wr_en), 0);
        chk("rst_rd_addr", int'(rd_addr), 0);
        chk("rst_wr_addr", int'(wr_addr), 0);
        chk("rst_wr_data", int'(wr_data), 0);
        // reset wins over a simultaneous start
        start = 1'b1;
        fator = 2'b01;
        @(negedge clk);
        start = 1'b0;
        chk("rst_over_start_busy", int'(busy), 0);
        rst = 1'b0;
        @(negedge clk);

        // T1: F=2
        run_job(2'b01, 0, bc);
        chk("t1_busy_cycles", bc, 25);

        // T2: F=1, frame region 0..3 must equal the source
        run_job(2'b00, 0, bc);
        chk("t2_busy_cycles", bc, 13);
        for (int a = 0; a < 4; a++) chk("t2_frame", fb[a], int'(mem[a]));

        // T3: F=4, full 8x8 frame covered exactly once
        wsnap = wcnt;
        run_job(2'b10, 0, bc);
        chk("t3_busy_cycles", bc, 73);
        for (int a = 0; a < 64; a++) chk("t3_write_once", wcnt[a] - wsnap[a], 1);
        for (int k = 0; k < 4; k++)
            for (int j = 0; j < 4; j++) chk("t3_block_36", fb[36 + 8 * k + j], 4);

        // T4: invalid fator, then a normal job
        run_job(2'b11, 0, bc);
        run_job(2'b01, 0, bc);
        chk("t4_busy_cycles", bc, 25);

        // T5: reset right after the 5th write of an F=2 job
        push_model(2);
        base  = done_cnt;
        start = 1'b1;
        fator = 2'b01;
        @(negedge clk);
        start = 1'b0;
        n   = 0;
        cnt = 0;
        while (n < 5 && cnt < 200) begin
            if (wr_en) n++;
            if (n < 5) @(negedge clk);
            cnt++;
        end
        chk("t5_reached_5th_write", n, 5);
        rst = 1'b1;
        @(negedge clk);
        chk("t5_wr_en_after_rst", int'(wr_en), 0);
        chk("t5_busy_after_rst", int'(busy), 0);
        rst = 1'b0;
        exp_q.delete();
        @(negedge clk);
        chk("t5_busy_idle", int'(busy), 0);
        chk("t5_no_done", done_cnt - base, 0);
        run_job(2'b01, 0, bc);
        chk("t5_restart_busy_cycles", bc, 25);

        // T6: start re-pulsed mid-job is ignored
        run_job(2'b01, 7, bc);
        chk("t6_busy_cycles", bc, 25);

        // Randomized jobs with random source contents and scale
        for (int r = 0; r < 10; r++) begin
            for (int a = 0; a < 4; a++) mem[a] = 8'($urandom_range(0, 255));
            f = int'($urandom_range(0, 3));
            run_job(2'(f), int'($urandom_range(0, 30)), bc);
            if (f != 3) chk("rand_busy_cycles", bc, W * H * (2 + (1 << f) * (1 << f)) + 1);
            repeat (int'($urandom_range(0, 3))) @(negedge clk);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
